ddr_write_issuer: RTL
=====================

DDR_WRITE_ISSUER -- requirements
Module: ddr_write_issuer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, DDR byte address width.
REQ-002 SHALL have parameter LEN_W, default 8, burst length field width (beats-1, AXI awlen encoding).
REQ-003 SHALL have parameter DATA_W, default 256, write data width.
REQ-004 SHALL have parameter MAX_OUTST, default 8, maximum AW bursts awaiting B response (power of 2, 2..16).
REQ-005 SHALL have ports, in order:
 clk  in  1  single clock, rising edge.
 rst_n  in  1  asynchronous active-low reset.
 info_dout  in  ADDR_W+LEN_W  write-info word from the write-info FIFO; [ADDR_W-1:0]=address, [ADDR_W+LEN_W-1:ADDR_W]=len.
 info_empty  in  1  write-info FIFO empty.
 info_rd_en  out  1  pop request to the write-info FIFO.
 s_wdata  in  DATA_W  payload stream data.
 s_wvalid  in  1  payload valid.
 s_wready  out  1  payload accepted when s_wvalid&s_wready.
 awaddr  out  ADDR_W  AXI write address.
 awlen  out  LEN_W  AXI burst length.
 awvalid  out  1 / awready  in  1  AW handshake.
 wdata  out  DATA_W / wlast  out  1 / wvalid  out  1 / wready  in  1  W channel.
 bresp  in  2 / bvalid  in  1 / bready  out  1  B channel.
 busy  out  1  any burst in progress or outstanding.
 err  out  1  sticky write-response error.

Function
REQ-006 SHALL implement FSM states IDLE, POP, LOAD, ADDR, DATA.
REQ-007 IDLE: when info_empty=0 and outstanding<MAX_OUTST, SHALL assert info_rd_en for exactly one cycle and go to POP; otherwise remain in IDLE.
REQ-008 info_rd_en SHALL never be asserted outside IDLE and never while info_empty=1.
REQ-009 POP: SHALL go to LOAD unconditionally (FIFO read latency 1 cycle).
REQ-010 LOAD: SHALL register address and len from info_dout, load beat counter with len, go to ADDR.
REQ-011 ADDR: awvalid SHALL be 1 with awaddr/awlen stable until awready=1; on handshake go to DATA.
REQ-012 DATA: s_wready SHALL equal wready and wvalid SHALL equal s_wvalid (combinational pass-through, zero latency); wdata SHALL equal s_wdata.
REQ-013 wlast SHALL be 1 exactly when beat counter=0 and state=DATA; each W handshake decrements counter; handshake with wlast=1 returns to IDLE.
REQ-014 Outside DATA, s_wready and wvalid SHALL be 0.
REQ-015 Outstanding counter SHALL increment on AW handshake, decrement on B handshake; both in same cycle leaves it unchanged; width clog2(MAX_OUTST)+1.
REQ-016 bready SHALL be constantly 1 after reset; B handshake with outstanding=0 SHALL be ignored (counter saturates at 0).
REQ-017 err SHALL set on any B handshake with bresp!=0 and hold until reset.
REQ-018 busy SHALL be 1 when state!=IDLE or outstanding!=0.
REQ-019 Burst of len=0 SHALL transfer one beat with wlast=1.
REQ-020 No new burst SHALL start (no pop) while outstanding=MAX_OUTST; a B handshake freeing a slot allows pop the following cycle.

Reset
REQ-021 On rst_n=0, state SHALL be IDLE asynchronously; info_rd_en, awvalid, wvalid, wlast, s_wready, err, busy SHALL be 0; outstanding and beat counter 0; awaddr, awlen 0.
REQ-022 Reset asserted mid-burst SHALL abandon the burst; after release no info_rd_en before info_empty=0 is sampled in IDLE.
REQ-023 bready SHALL be 0 during reset, 1 from first clock after release.

Verification
REQ-024 Single burst: info addr=0x1000 len=3, awready=1, wready=1, 4 beats -> one info_rd_en pulse, awaddr=0x1000 awlen=3, wlast on 4th beat, busy falls after bresp=0.
REQ-025 Backpressure: awready held 0 for 5 cycles, wready toggled -> awvalid/awaddr stable, beats delivered in order, counter counts only handshakes.
REQ-026 Outstanding limit: MAX_OUTST=8, no B responses, 10 info entries len=0 -> exactly 8 AW handshakes, then no info_rd_en until a bvalid; 9th starts next cycle after B.
REQ-027 Error: bresp=2 on one response -> err=1 and stays 1 through further OKAY responses until rst_n=0.
REQ-028 Simultaneous AW and B handshake with outstanding=3 -> outstanding stays 3.
REQ-029 Reset mid-DATA after 2 of 4 beats -> all outputs at reset values immediately; new burst proceeds normally after release.

Source files
------------

// File: rtl/ddr_write_issuer.sv
// Issues AXI write bursts from a write-info FIFO: one AW per info word, then a
// zero-latency pass-through of the payload stream, while tracking B responses.
module ddr_write_issuer #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 8,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W+LEN_W-1:0] info_dout,
    input  logic                    info_empty,
    output logic                    info_rd_en,
    input  logic [DATA_W-1:0]       s_wdata,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [LEN_W-1:0]        awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_W-1:0]       wdata,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic                    err
);
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTST);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_ADDR, S_DATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [OW-1:0]     outst_q;
    logic              err_q;
    logic              run_q;
    logic              aw_hs, w_hs, b_hs, b_dec;

    // run_q is low in reset and for the first cycle after release; it gates
    // both bready and the first pop so nothing happens before a real clock.
    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign b_hs   = bvalid & run_q;
    assign b_dec  = b_hs & (outst_q != '0);

    assign awaddr = addr_q;
    assign awlen  = len_q;
    assign wdata  = s_wdata;
    assign bready = run_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE) || (outst_q != '0);

    always_comb begin
        state_d    = state_q;
        info_rd_en = 1'b0;
        awvalid    = 1'b0;
        s_wready   = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_q && !info_empty && (outst_q < OUT_MAX)) begin
                    info_rd_en = 1'b1;
                    state_d    = S_POP;
                end
            end
            S_POP:  state_d = S_LOAD;
            S_LOAD: state_d = S_ADDR;
            S_ADDR: begin
                awvalid = 1'b1;
                if (awready) state_d = S_DATA;
            end
            S_DATA: begin
                s_wready = wready;
                wvalid   = s_wvalid;
                wlast    = (beat_q == '0);
                if (s_wvalid && wready && (beat_q == '0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (state_q == S_LOAD) begin
                addr_q <= info_dout[ADDR_W-1:0];
                len_q  <= info_dout[ADDR_W +: LEN_W];
                beat_q <= info_dout[ADDR_W +: LEN_W];
            end else if (w_hs) begin
                beat_q <= beat_q - 1'b1;
            end
            // A B response with nothing outstanding is dropped, so the count never wraps.
            case ({aw_hs, b_dec})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            if (b_hs && (bresp != 2'b00)) err_q <= 1'b1;
        end
    end
endmodule
